rv32imf_irq_wake_ctrl: RTL and testbench

Interrupt capture and wake-request block feeding the sleep unit's wake_from_sleep input and the controller's interrupt request.
- Runs on the ungated clock so it can wake a sleeping core.
- Registers external level-sensitive interrupt lines and masks them with MIE.
- Prioritises them and presents one request to the controller with an id, held stable until acknowledged.
- Raises a wake request whenever any enabled interrupt is pending, independent of mstatus.MIE, per RISC-V WFI semantics.

---
 rtl/rv32imf_pkg.sv | 16 +
 rtl/rv32imf_irq_prio_enc.sv | 37 +++
 rtl/rv32imf_irq_wake_ctrl.sv | 137 +++++++++++++
 tb/tb_rv32imf_irq_wake_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/rv32imf_pkg.sv
// Shared definitions for the rv32imf interrupt path: fixed interrupt ids
// and the interrupt-request FSM state encoding.
package rv32imf_pkg;

    localparam logic [4:0] IRQ_MSI     = 5'd3;
    localparam logic [4:0] IRQ_MTI     = 5'd7;
    localparam logic [4:0] IRQ_MEI     = 5'd11;
    localparam logic [4:0] IRQ_FAST_LO = 5'd16;

    typedef enum logic [1:0] {
        IRQ_IDLE,
        IRQ_REQ,
        IRQ_HOLD
    } irq_fsm_e;

endpackage

// File: rtl/rv32imf_irq_prio_enc.sv
// Combinational priority encoder over a 32-bit pending vector.
// Order, highest first: 31..16 (fast), 11 (MEI), 3 (MSI), 7 (MTI).
// Every other bit is ignored.
module rv32imf_irq_prio_enc
    import rv32imf_pkg::*;
(
    input  logic [31:0] pending,
    output logic [4:0]  best_id,
    output logic        best_valid
);

    // Lowest priority is assigned first so that later, higher-priority hits overwrite it.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        best_id    = '0;
        best_valid = 1'b0;
        if (pending[IRQ_MTI]) begin
            best_id    = IRQ_MTI;
            best_valid = 1'b1;
        end
        if (pending[IRQ_MSI]) begin
            best_id    = IRQ_MSI;
            best_valid = 1'b1;
        end
        if (pending[IRQ_MEI]) begin
            best_id    = IRQ_MEI;
            best_valid = 1'b1;
        end
        for (int i = 16; i < 32; i++) begin
            if (pending[i]) begin
                best_id    = 5'(i);
                best_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rv32imf_irq_wake_ctrl.sv
// Interrupt capture, prioritisation and wake-request generation.
// Runs on the ungated clock so a pending interrupt can wake a sleeping core.
// Optional macro IRQ_SYNC_EN: adds a 2-flop synchroniser in front of the
// capture register for asynchronous interrupt sources.
module rv32imf_irq_wake_ctrl
    import rv32imf_pkg::*;
#(
    parameter int NUM_IRQ     = 32,
    parameter int HOLD_CYCLES = 1
) (
    input  logic               clk_i,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] irq_i,
    input  logic [NUM_IRQ-1:0] mie_i,
    input  logic               m_ie_i,
    input  logic               debug_mode_i,
    input  logic               irq_ack_i,
    input  logic [4:0]         irq_ack_id_i,
    output logic               irq_req_o,
    output logic [4:0]         irq_id_o,
    output logic [NUM_IRQ-1:0] mip_o,
    output logic               wake_from_sleep_o
);

    localparam logic [1:0] HOLD_INIT = 2'(HOLD_CYCLES);

    logic [NUM_IRQ-1:0] irq_src;
    logic [NUM_IRQ-1:0] irq_q;
    logic [NUM_IRQ-1:0] pending;
    logic [31:0]        pend32;
    logic [4:0]         best_id;
    logic               best_valid;
    logic               wake_q;

    irq_fsm_e   state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic [4:0] id_q, id_d;

`ifdef IRQ_SYNC_EN
    logic [NUM_IRQ-1:0] sync_q1, sync_q2;

    // Two-stage synchroniser for interrupt lines from other clock domains.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= irq_i;
            sync_q2 <= sync_q1;
        end
    end

    assign irq_src = sync_q2;
`else
    assign irq_src = irq_i;
`endif

    // Capture interrupt levels every cycle; this register is also the mip view.
    always_ff @(posedge clk_i or negedge rst_n) begin
        // NOTE: flop state uses non-blocking assignment so all registers update together.
        if (!rst_n) irq_q <= '0;
        else        irq_q <= irq_src;
    end

    assign pending = irq_q & mie_i;
    assign mip_o   = irq_q;

    // Widen to 32 bits; lines beyond NUM_IRQ-1 read as zero.
    always_comb begin
        pend32               = '0;
        pend32[NUM_IRQ-1:0]  = pending;
    end

    rv32imf_irq_prio_enc u_prio_enc (
        .pending    (pend32),
        .best_id    (best_id),
        .best_valid (best_valid)
    );

    // Wake ignores mstatus.MIE and debug mode: WFI must resume on any enabled pending source.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) wake_q <= 1'b0;
        else        wake_q <= |pending;
    end

    assign wake_from_sleep_o = wake_q;

    // FSM state, hold counter and frozen request id.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IRQ_IDLE;
            cnt_q   <= '0;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            id_q    <= id_d;
        end
    end

    // Next-state logic: pick in IDLE, freeze in REQ, back off in HOLD after an ack.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        id_d    = id_q;
        unique case (state_q)
            IRQ_IDLE: begin
                if (best_valid && m_ie_i && !debug_mode_i) begin
                    id_d    = best_id;
                    state_d = IRQ_REQ;
                end
            end
            IRQ_REQ: begin
                // A matching ack wins over a simultaneous withdraw.
                if (irq_ack_i && (irq_ack_id_i == id_q)) begin
                    cnt_d   = HOLD_INIT;
                    state_d = IRQ_HOLD;
                end else if (!pend32[id_q] || !m_ie_i || debug_mode_i) begin
                    state_d = IRQ_IDLE;
                end
            end
            IRQ_HOLD: begin
                if (cnt_q <= 2'd1) begin
                    cnt_d   = '0;
                    state_d = IRQ_IDLE;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            default: state_d = IRQ_IDLE;
        endcase
    end

    assign irq_req_o = (state_q == IRQ_REQ);
    assign irq_id_o  = id_q;

endmodule

// File: tb/tb_rv32imf_irq_wake_ctrl.sv
// Directed self-checking bench for rv32imf_irq_wake_ctrl.
module tb_rv32imf_irq_wake_ctrl;

`ifdef IRQ_SYNC_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 2;
`endif

    logic        clk_i;
    logic        rst_n;
    logic [31:0] irq_i;
    logic [31:0] mie_i;
    logic        m_ie_i;
    logic        debug_mode_i;
    logic        irq_ack_i;
    logic [4:0]  irq_ack_id_i;
    logic        irq_req_o;
    logic [4:0]  irq_id_o;
    logic [31:0] mip_o;
    logic        wake_from_sleep_o;

    int checks = 0;
    int errors = 0;

    rv32imf_irq_wake_ctrl #(
        .NUM_IRQ     (32),
        .HOLD_CYCLES (1)
    ) dut (
        .clk_i             (clk_i),
        .rst_n             (rst_n),
        .irq_i             (irq_i),
        .mie_i             (mie_i),
        .m_ie_i            (m_ie_i),
        .debug_mode_i      (debug_mode_i),
        .irq_ack_i         (irq_ack_i),
        .irq_ack_id_i      (irq_ack_id_i),
        .irq_req_o         (irq_req_o),
        .irq_id_o          (irq_id_o),
        .mip_o             (mip_o),
        .wake_from_sleep_o (wake_from_sleep_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic ack(input logic [4:0] id);
        irq_ack_i    = 1'b1;
        irq_ack_id_i = id;
        step(1);
        irq_ack_i    = 1'b0;
        irq_ack_id_i = '0;
    endtask

    initial begin
        rst_n        = 1'b1;
        irq_i        = '0;
        mie_i        = '0;
        m_ie_i       = 1'b0;
        debug_mode_i = 1'b0;
        irq_ack_i    = 1'b0;
        irq_ack_id_i = '0;
        #1 rst_n = 1'b0;
        #2;
        check("rst_req",  {31'd0, irq_req_o}, 32'd0);
        check("rst_id",   {27'd0, irq_id_o}, 32'd0);
        check("rst_mip",  mip_o, 32'd0);
        check("rst_wake", {31'd0, wake_from_sleep_o}, 32'd0);
        #17 rst_n = 1'b1;
        step(1);

        // MEI: wake and request appear LAT cycles after irq_i.
        irq_i  = 32'h0000_0800;
        mie_i  = 32'h0000_0800;
        m_ie_i = 1'b1;
        step(LAT - 1);
        check("mei_req_early",  {31'd0, irq_req_o}, 32'd0);
        check("mei_wake_early", {31'd0, wake_from_sleep_o}, 32'd0);
        check("mei_mip",        mip_o, 32'h0000_0800);
        step(1);
        check("mei_req",  {31'd0, irq_req_o}, 32'd1);
        check("mei_id",   {27'd0, irq_id_o}, 32'd11);
        check("mei_wake", {31'd0, wake_from_sleep_o}, 32'd1);

`ifndef IRQ_SYNC_EN
        // 0x888 all enabled: MEI beats MSI and MTI.
        irq_i = 32'h0000_0888;
        mie_i = 32'hFFFF_FFFF;
        step(2);
        check("prio_888_id", {27'd0, irq_id_o}, 32'd11);
        ack(5'd11);
        irq_i = 32'h0000_0088;
        check("ack11_req_drop", {31'd0, irq_req_o}, 32'd0);
        step(1);
        check("ack11_idle", {31'd0, irq_req_o}, 32'd0);
        step(1);
        check("msi_req", {31'd0, irq_req_o}, 32'd1);
        check("msi_id",  {27'd0, irq_id_o}, 32'd3);
        ack(5'd3);
        irq_i = 32'h0000_0080;
        step(2);
        check("mti_req", {31'd0, irq_req_o}, 32'd1);
        check("mti_id",  {27'd0, irq_id_o}, 32'd7);

        // Higher-priority arrival must not change the frozen id.
        irq_i = 32'h0010_0080;
        step(2);
        check("frozen_id",  {27'd0, irq_id_o}, 32'd7);
        ack(5'd5);
        check("bad_ack_req", {31'd0, irq_req_o}, 32'd1);
        check("bad_ack_id",  {27'd0, irq_id_o}, 32'd7);
        ack(5'd7);
        check("ack7_drop", {31'd0, irq_req_o}, 32'd0);
        step(2);
        check("fast20_req", {31'd0, irq_req_o}, 32'd1);
        check("fast20_id",  {27'd0, irq_id_o}, 32'd20);

        // Withdraw the active source: request drops, then MTI is picked.
        irq_i = 32'h0000_0080;
        step(2);
        check("withdraw20_req", {31'd0, irq_req_o}, 32'd0);
        step(1);
        check("repick_req", {31'd0, irq_req_o}, 32'd1);
        check("repick_id",  {27'd0, irq_id_o}, 32'd7);
        irq_i = 32'h0;
        step(2);
        check("withdraw7_req",  {31'd0, irq_req_o}, 32'd0);
        check("withdraw7_wake", {31'd0, wake_from_sleep_o}, 32'd0);

        // Global disable: wake still asserted, no request.
        m_ie_i = 1'b0;
        irq_i  = 32'h0000_0080;
        mie_i  = 32'h0000_0080;
        step(2);
        check("mie0_wake", {31'd0, wake_from_sleep_o}, 32'd1);
        for (int i = 0; i < 20; i++) begin
            check("mie0_no_req", {31'd0, irq_req_o}, 32'd0);
            step(1);
        end

        // Debug mode suppresses the request; leaving debug releases it.
        m_ie_i       = 1'b1;
        debug_mode_i = 1'b1;
        step(3);
        check("debug_no_req", {31'd0, irq_req_o}, 32'd0);
        check("debug_wake",   {31'd0, wake_from_sleep_o}, 32'd1);
        debug_mode_i = 1'b0;
        step(1);
        check("undebug_req", {31'd0, irq_req_o}, 32'd1);
        check("undebug_id",  {27'd0, irq_id_o}, 32'd7);

        // Unranked bit 5 wakes but never requests.
        irq_i = 32'h0000_0020;
        mie_i = 32'h0000_0020;
        step(4);
        check("bit5_wake", {31'd0, wake_from_sleep_o}, 32'd1);
        check("bit5_req",  {31'd0, irq_req_o}, 32'd0);

        // Asynchronous reset in the middle of a request.
        irq_i = 32'h0000_0080;
        mie_i = 32'h0000_0080;
        step(2);
        check("pre_rst_req", {31'd0, irq_req_o}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_req",  {31'd0, irq_req_o}, 32'd0);
        check("arst_id",   {27'd0, irq_id_o}, 32'd0);
        check("arst_mip",  mip_o, 32'd0);
        check("arst_wake", {31'd0, wake_from_sleep_o}, 32'd0);
        @(negedge clk_i);
        rst_n = 1'b1;
        step(1);
        check("post_rst_req_early", {31'd0, irq_req_o}, 32'd0);
        step(1);
        check("post_rst_req", {31'd0, irq_req_o}, 32'd1);
        check("post_rst_id",  {27'd0, irq_id_o}, 32'd7);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
